// File: rtl/fire_sched_pkg.sv
// -----------------------------------------------------------------------------
// fire_sched_pkg
// Shared definitions for the fire-line scheduler: FSM state encoding, default
// timing constants and small elaboration-time helpers.
// Optional feature macro: FIRE_SHIFT_TIMEOUT_EN (uses DefTimeoutCyc).
// -----------------------------------------------------------------------------
package fire_sched_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StReq   = 3'd1,
      StAck   = 3'd2,
      StShift = 3'd3,
      StLat   = 3'd4,
      StGap   = 3'd5
   } sched_state_e;

   localparam int unsigned DefLatWidth   = 8;
   localparam int unsigned DefMinGap     = 16;
   localparam int unsigned DefCntW       = 16;
   localparam int unsigned DefTimeoutCyc = 4096;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int unsigned cyc_width(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/fire_trig_queue.sv
// -----------------------------------------------------------------------------
// fire_trig_queue
// One-deep trigger queue with sticky overrun flag for the fire-line scheduler.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   trig         qualified fire trigger (already gated by enable / !done)
//   start        scheduler leaves IDLE this cycle (consumes any pending entry)
//   flush        drop the pending entry (enable low or shift timeout)
//   overrun_clr  clears the overrun flag; a simultaneous set wins
//   pending      a trigger is waiting for the current line to finish
//   overrun      sticky: a trigger arrived while the queue was full
// -----------------------------------------------------------------------------
module fire_trig_queue
   import fire_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic trig,
   input  logic start,
   input  logic flush,
   input  logic overrun_clr,
   output logic pending,
   output logic overrun
);

   logic pending_q, pending_d;
   logic overrun_q, overrun_d;
   logic overrun_set;

   always_comb begin
      pending_d   = pending_q;
      overrun_set = 1'b0;
      if (flush) begin
         pending_d = 1'b0;
      end else if (start) begin
         // With an entry waiting, a trigger in the consume cycle refills the
         // queue; without one, that trigger is the one starting the line.
         pending_d = pending_q & trig;
      end else if (trig) begin
         if (pending_q) begin
            overrun_set = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end

      overrun_d = overrun_q;
      if (overrun_set) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign pending = pending_q;
   assign overrun = overrun_q;

endmodule

// File: rtl/fire_line_scheduler.sv
// -----------------------------------------------------------------------------
// fire_line_scheduler
// Per-line sequencer between encoder fire triggers and the head data-shift
// engine: request a shift, wait for the engine to run, pulse the head latch,
// start the waveform generator, then hold a guard gap. Also counts lines,
// queues one trigger, flags overruns and reports pass completion.
//
// Optional feature macro: FIRE_SHIFT_TIMEOUT_EN adds parameter TIMEOUT_CYC and
// sticky output timeout; ACK/SHIFT then abort to IDLE after TIMEOUT_CYC cycles.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       pass enable (level)
//   fire_trig    single-cycle encoder fire pulse
//   line_total   lines in pass, 0 = unlimited
//   head_idle    shift engine idle flag
//   overrun_clr  clears overrun (and timeout when present)
//   sck_req      shift request to engine
//   lat_o        head latch pulse, LAT_WIDTH cycles
//   wave_start   single-cycle waveform start
//   busy         scheduler not in IDLE
//   line_cnt     lines completed in current pass
//   done         pass complete (level)
//   overrun      sticky: trigger lost
//   timeout      sticky: shift engine did not finish (macro only)
// -----------------------------------------------------------------------------
module fire_line_scheduler
   import fire_sched_pkg::*;
#(
   parameter int unsigned LAT_WIDTH   = DefLatWidth,
   parameter int unsigned MIN_GAP     = DefMinGap,
   parameter int unsigned CNT_W       = DefCntW
`ifdef FIRE_SHIFT_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fire_trig,
   input  logic [CNT_W-1:0] line_total,
   input  logic             head_idle,
   input  logic             overrun_clr,
   output logic             sck_req,
   output logic             lat_o,
   output logic             wave_start,
   output logic             busy,
   output logic [CNT_W-1:0] line_cnt,
   output logic             done,
   output logic             overrun
`ifdef FIRE_SHIFT_TIMEOUT_EN
   ,
   output logic             timeout
`endif
);

`ifdef FIRE_SHIFT_TIMEOUT_EN
   localparam int unsigned CycMax = max3(LAT_WIDTH, MIN_GAP, TIMEOUT_CYC);
`else
   localparam int unsigned CycMax = max3(LAT_WIDTH, MIN_GAP, 0);
`endif
   localparam int unsigned     CycW    = cyc_width(CycMax);
   localparam logic [CycW-1:0] LatLast = CycW'(LAT_WIDTH - 1);
   localparam logic [CycW-1:0] GapLast = CycW'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);
`ifdef FIRE_SHIFT_TIMEOUT_EN
   localparam logic [CycW-1:0] TmoLast = CycW'(TIMEOUT_CYC - 1);
`endif

   sched_state_e     state_q, state_d;
   logic [CycW-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic             done_q, done_d;
   logic             wave_q;
   logic             pending;
   logic             trig_ok;
   logic             start;
   logic             lat_entry;
   logic             lat_done;
   logic             flush;
   logic             tmo_hit;

   // Triggers count only while enabled and the pass is not finished.
   assign trig_ok = fire_trig & enable & ~done_q;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      lat_entry = 1'b0;
      lat_done  = 1'b0;
      tmo_hit   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable && !done_q && (fire_trig || pending)) begin
               state_d = StReq;
               start   = 1'b1;
            end
         end
         StReq: begin
            state_d = StAck;
         end
         StAck: begin
            // head_idle may still be high here; only its fall means the
            // engine took the request.
            if (!head_idle) begin
               state_d = StShift;
            end
`ifdef FIRE_SHIFT_TIMEOUT_EN
            else if (cyc_q == TmoLast) begin
               tmo_hit = 1'b1;
               state_d = StIdle;
            end
`endif
         end
         StShift: begin
            if (head_idle) begin
               state_d   = StLat;
               lat_entry = 1'b1;
            end
`ifdef FIRE_SHIFT_TIMEOUT_EN
            else if (cyc_q == TmoLast) begin
               tmo_hit = 1'b1;
               state_d = StIdle;
            end
`endif
         end
         StLat: begin
            if (cyc_q == LatLast) begin
               lat_done = 1'b1;
               state_d  = (MIN_GAP == 0) ? StIdle : StGap;
            end
         end
         StGap: begin
            if (cyc_q == GapLast) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Shared cycle counter: restarts on each state change, except ACK->SHIFT so
   // the shift timeout spans both waiting states.
   always_comb begin
      cyc_d = cyc_q + 1'b1;
      if ((state_d != state_q) && !((state_q == StAck) && (state_d == StShift))) begin
         cyc_d = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Line counter and pass completion
   // ---------------------------------------------------------------------------
   always_comb begin
      line_cnt_d = line_cnt_q;
      done_d     = done_q;
      if (lat_entry) begin
         line_cnt_d = line_cnt_q + CNT_W'(1);
         if ((line_total != '0) && (line_cnt_d == line_total)) begin
            done_d = 1'b1;
         end
      end else if ((state_q == StIdle) && !enable) begin
         line_cnt_d = '0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cyc_q      <= '0;
         line_cnt_q <= '0;
         done_q     <= 1'b0;
         wave_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         line_cnt_q <= line_cnt_d;
         done_q     <= done_d;
         // Pulses in the first cycle after the latch, whether or not a gap follows.
         wave_q     <= lat_done;
      end
   end

`ifdef FIRE_SHIFT_TIMEOUT_EN
   logic timeout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else if (tmo_hit) begin
         timeout_q <= 1'b1;
      end else if (overrun_clr) begin
         timeout_q <= 1'b0;
      end
   end

   assign timeout = timeout_q;
   assign flush   = ~enable | tmo_hit;
`else
   assign flush   = ~enable | tmo_hit;
`endif

   // ---------------------------------------------------------------------------
   // Trigger queue
   // ---------------------------------------------------------------------------
   fire_trig_queue u_queue (
      .clk         (clk),
      .rst         (rst),
      .trig        (trig_ok),
      .start       (start),
      .flush       (flush),
      .overrun_clr (overrun_clr),
      .pending     (pending),
      .overrun     (overrun)
   );

   // Decoded from state so reset removes them without waiting for a clock.
   assign sck_req    = (state_q == StReq);
   assign lat_o      = (state_q == StLat);
   assign busy       = (state_q != StIdle);
   assign wave_start = wave_q;
   assign line_cnt   = line_cnt_q;
   assign done       = done_q;

endmodule
